// File: rtl/sram_sp_bwe_init.sv
// Parametrised single-port SRAM model: per-bit write mask, 1/2-cycle read latency, reset-driven init sweep.
// Optional feature macro SRAM_RANDOM_OUT_EN: when defined, Q is loaded with random data on non-read slots.
module sram_sp_bwe_init #(
    parameter int              Bits          = 8,
    parameter int              Word_Depth    = 256,
    parameter int              Add_Width     = 8,
    parameter int              Read_Latency  = 1,
    parameter int              Init_On_Reset = 1,
    parameter logic [Bits-1:0] Init_Value    = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [Add_Width-1:0] A,
    input  logic [Bits-1:0]      D,
    input  logic [Bits-1:0]      BWEB,
    output logic [Bits-1:0]      Q,
    output logic                 QV,
    output logic                 INIT_DONE
);
    localparam int                   IdxW      = $clog2(Word_Depth);
    localparam logic [Add_Width:0]   DepthW    = (Add_Width + 1)'(Word_Depth);
    localparam logic [Add_Width-1:0] LastAddr  = Add_Width'(Word_Depth - 1);
    localparam int                   RandReps  = (Bits + 31) / 32;

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    state_t                next_state;
    logic [Add_Width-1:0]  cnt;
    logic [Bits-1:0]       ram [Word_Depth];
    logic [IdxW-1:0]       a_idx;
    logic [IdxW-1:0]       cnt_idx;
    logic                  in_range;
    logic                  sweep_wr;
    logic                  user_wr;
    logic                  rd_req;
    logic [Bits-1:0]       rd_data;
    logic                  slot_valid;
    logic [Bits-1:0]       slot_data;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= (Init_On_Reset != 0) ? INIT : READY;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == INIT && cnt == LastAddr)
            next_state = READY;
    end

    // Requests are only honoured once the sweep has finished; reads see the array before this edge.
    always_comb begin
        a_idx     = A[IdxW-1:0];
        cnt_idx   = cnt[IdxW-1:0];
        in_range  = {1'b0, A} < DepthW;
        sweep_wr  = (state == INIT);
        user_wr   = (state == READY) && !CEB && !WEB && in_range;
        rd_req    = (state == READY) && !CEB && WEB;
        rd_data   = in_range ? ram[a_idx] : '0;
        INIT_DONE = (state == READY);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (sweep_wr)
            cnt <= cnt + Add_Width'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (sweep_wr)
                ram[cnt_idx] <= Init_Value;
            else if (user_wr)
                ram[a_idx] <= (ram[a_idx] & BWEB) | (D & ~BWEB);
        end
    end

    generate
        if (Read_Latency == 2) begin : g_lat2
            logic            s1_valid;
            logic [Bits-1:0] s1_data;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else begin
                    s1_valid <= rd_req;
                    if (rd_req)
                        s1_data <= rd_data;
                end
            end

            assign slot_valid = s1_valid;
            assign slot_data  = s1_data;
        end else begin : g_lat1
            assign slot_valid = rd_req;
            assign slot_data  = rd_data;
        end
    endgenerate

    // Final output stage: empty slots either hold Q or scramble it to flush out QV-less consumers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q  <= '0;
            QV <= 1'b0;
        end else begin
            QV <= slot_valid;
            if (slot_valid)
                Q <= slot_data;
`ifdef SRAM_RANDOM_OUT_EN
            else
                Q <= Bits'({RandReps{$random}});
`endif
        end
    end
endmodule

// File: tb/tb_sram_sp_bwe_init.sv
// Self-checking bench for sram_sp_bwe_init: two instances (16 words/latency 2, 12 words/latency 1)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_sram_sp_bwe_init;
    logic       clk = 1'b0;
    logic       rst;
    logic       ceb;
    logic       web;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] bweb;

    logic [7:0] q_out    [2];
    logic       qv_out   [2];
    logic       done_out [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_sp_bwe_init #(
        .Bits(8), .Word_Depth(16), .Add_Width(5), .Read_Latency(2),
        .Init_On_Reset(1), .Init_Value(8'hA5)
    ) dut0 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
        .Q(q_out[0]), .QV(qv_out[0]), .INIT_DONE(done_out[0])
    );

    sram_sp_bwe_init #(
        .Bits(8), .Word_Depth(12), .Add_Width(4), .Read_Latency(1),
        .Init_On_Reset(1), .Init_Value(8'hA5)
    ) dut1 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a[3:0]), .D(d), .BWEB(bweb),
        .Q(q_out[1]), .QV(qv_out[1]), .INIT_DONE(done_out[1])
    );

    // Behavioural model: words still to sweep, array contents, and the read result due at the output.
    int         depth     [2] = '{16, 12};
    int         latency   [2] = '{2, 1};
    logic [7:0] mem       [2][32];
    int         remaining [2];
    logic       pipe_v    [2];
    logic [7:0] pipe_d    [2];
    logic [7:0] exp_q     [2];
    logic       exp_qv    [2];
    bit         model_live = 1'b0;

    task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        int         addr;
        logic       sv;
        logic [7:0] sd;
        logic       ov;
        logic [7:0] od;
        if (rst)
            model_live = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                remaining[k] = depth[k];
                pipe_v[k]    = 1'b0;
                exp_q[k]     = 8'h00;
                exp_qv[k]    = 1'b0;
            end else if (model_live) begin
                addr = (k == 0) ? int'(a) : int'(a[3:0]);
                sv   = 1'b0;
                sd   = 8'h00;
                if (remaining[k] > 0) begin
                    mem[k][depth[k] - remaining[k]] = 8'hA5;
                    remaining[k] = remaining[k] - 1;
                end else if (!ceb && web) begin
                    sv = 1'b1;
                    sd = (addr < depth[k]) ? mem[k][addr] : 8'h00;
                end else if (!ceb && !web && addr < depth[k]) begin
                    for (int b = 0; b < 8; b++)
                        if (!bweb[b])
                            mem[k][addr][b] = d[b];
                end
                if (latency[k] == 1) begin
                    ov = sv;
                    od = sd;
                end else begin
                    ov = pipe_v[k];
                    od = pipe_d[k];
                    pipe_v[k] = sv;
                    pipe_d[k] = sd;
                end
                exp_qv[k] = ov;
                if (ov)
                    exp_q[k] = od;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("m%0d_done", k), {8'h00, done_out[k]}, {8'h00, remaining[k] == 0});
                checkOutput($sformatf("m%0d_qv", k), {8'h00, qv_out[k]}, {8'h00, exp_qv[k]});
                checkOutput($sformatf("m%0d_q", k), {1'b0, q_out[k]}, {1'b0, exp_q[k]});
            end
        end
    end

    task automatic applyStimulus(input logic c, input logic w, input logic [4:0] ad,
                                 input logic [7:0] dd, input logic [7:0] bw);
        ceb  = c;
        web  = w;
        a    = ad;
        d    = dd;
        bweb = bw;
        @(negedge clk);
    endtask

    task automatic doIdle();
        applyStimulus(1'b1, 1'b1, 5'd0, 8'h00, 8'hFF);
    endtask

    task automatic doRead(input logic [4:0] ad);
        applyStimulus(1'b0, 1'b1, ad, 8'h00, 8'hFF);
    endtask

    task automatic doWrite(input logic [4:0] ad, input logic [7:0] dd, input logic [7:0] bw);
        applyStimulus(1'b0, 1'b0, ad, dd, bw);
    endtask

    task automatic expectOut(input string name, input int k, input logic v, input logic [7:0] q);
        checkOutput(name, {qv_out[k], q_out[k]}, {v, q});
    endtask

    task automatic expectQv(input string name, input int k, input logic v);
        checkOutput(name, {8'h00, qv_out[k]}, {8'h00, v});
    endtask

    // Runs idle (or scripted) cycles until both instances report done; returns the edge count of each.
    task automatic waitSweep(input bit with_requests, output int first0, output int first1);
        first0 = 0;
        first1 = 0;
        for (int n = 1; n <= 40; n++) begin
            if (with_requests && n == 5)
                doRead(5'd4);
            else if (with_requests && n == 10)
                doWrite(5'd0, 8'h00, 8'h00);
            else
                doIdle();
            if (with_requests && n == 5)
                expectQv("sweep_read_ignored", 1, 1'b0);
            if (done_out[0] === 1'b1 && first0 == 0)
                first0 = n;
            if (done_out[1] === 1'b1 && first1 == 0)
                first1 = n;
            if (first0 != 0 && first1 != 0)
                break;
        end
    endtask

    initial begin
        int f0;
        int f1;
        int r;
        rst  = 1'b1;
        ceb  = 1'b1;
        web  = 1'b1;
        a    = 5'd0;
        d    = 8'h00;
        bweb = 8'hFF;
        @(negedge clk);
        expectOut("reset_q0", 0, 1'b0, 8'h00);
        expectQv("reset_done0", 0, done_out[0] == 1'b1);
        doIdle();
        doIdle();
        rst = 1'b0;

        $display("[TB] init sweep");
        waitSweep(1'b1, f0, f1);
        checkOutput("sweep_len_16", 9'(f0), 9'd16);
        checkOutput("sweep_len_12", 9'(f1), 9'd12);

        $display("[TB] read back sweep");
        for (int i = 0; i <= 16; i++) begin
            if (i < 16)
                doRead(5'(i));
            else
                doIdle();
            if (i < 12)
                expectOut($sformatf("sweep_rd1_%0d", i), 1, 1'b1, 8'hA5);
            else if (i < 16)
                expectOut($sformatf("sweep_rd1_%0d", i), 1, 1'b1, 8'h00);
            if (i >= 1)
                expectOut($sformatf("sweep_rd0_%0d", i - 1), 0, 1'b1, 8'hA5);
        end

        $display("[TB] bit mask");
        doWrite(5'd3, 8'hFF, 8'h00);
        doWrite(5'd3, 8'h00, 8'hF0);
        doRead(5'd3);
        expectOut("mask_rd1", 1, 1'b1, 8'hF0);
        doIdle();
        expectOut("mask_rd0", 0, 1'b1, 8'hF0);

        $display("[TB] read latency");
        doWrite(5'd1, 8'h11, 8'h00);
        doWrite(5'd2, 8'h22, 8'h00);
        doWrite(5'd3, 8'h33, 8'h00);
        expectQv("lat_before0", 0, 1'b0);
        doRead(5'd1);
        expectQv("lat_e1_0", 0, 1'b0);
        expectOut("lat_e1_1", 1, 1'b1, 8'h11);
        doRead(5'd2);
        expectOut("lat_e2_0", 0, 1'b1, 8'h11);
        expectOut("lat_e2_1", 1, 1'b1, 8'h22);
        doRead(5'd3);
        expectOut("lat_e3_0", 0, 1'b1, 8'h22);
        expectOut("lat_e3_1", 1, 1'b1, 8'h33);
        doIdle();
        expectOut("lat_e4_0", 0, 1'b1, 8'h33);
        expectQv("lat_e4_1", 1, 1'b0);
        doIdle();
        expectQv("lat_e5_0", 0, 1'b0);

        $display("[TB] non-read hold");
        doRead(5'd2);
        expectOut("hold_rd1", 1, 1'b1, 8'h22);
        doIdle();
        expectOut("hold_i1_0", 0, 1'b1, 8'h22);
        expectOut("hold_i1_1", 1, 1'b0, 8'h22);
        doIdle();
        expectOut("hold_i2_0", 0, 1'b0, 8'h22);
        expectOut("hold_i2_1", 1, 1'b0, 8'h22);
        doIdle();
        expectOut("hold_i3_0", 0, 1'b0, 8'h22);
        expectOut("hold_i3_1", 1, 1'b0, 8'h22);

        $display("[TB] out of range");
        doWrite(5'd29, 8'h5A, 8'h00);
        doRead(5'd29);
        expectOut("oor_rd1", 1, 1'b1, 8'h00);
        doRead(5'd1);
        expectOut("oor_rd0", 0, 1'b1, 8'h00);
        expectOut("alias_rd1", 1, 1'b1, 8'h11);
        doRead(5'd13);
        expectOut("oor13_rd1", 1, 1'b1, 8'h00);
        doIdle();
        expectOut("alias13_rd0", 0, 1'b1, 8'hA5);

        $display("[TB] reset mid-sweep");
        rst = 1'b1;
        doIdle();
        rst = 1'b0;
        for (int n = 0; n < 7; n++)
            doIdle();
        expectQv("mid_not_done1", 1, done_out[1] == 1'b1);
        rst = 1'b1;
        doIdle();
        rst = 1'b0;
        waitSweep(1'b0, f0, f1);
        checkOutput("resweep_len_16", 9'(f0), 9'd16);
        checkOutput("resweep_len_12", 9'(f1), 9'd12);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)
                doIdle();
            else if (r < 6)
                doRead(5'($urandom_range(0, 31)));
            else begin
                case ($urandom_range(0, 3))
                    0:       doWrite(5'($urandom_range(0, 31)), 8'($urandom), 8'h00);
                    1:       doWrite(5'($urandom_range(0, 31)), 8'($urandom), 8'hFF);
                    default: doWrite(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom));
                endcase
            end
        end
        doIdle();
        doIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_sp_bwe_init.md
Name: sram_sp_bwe_init

Overview:
- Parametrised single-port SRAM behavioural model for simulation and FPGA builds.
- Generalises the fixed 256x8 macro model to arbitrary width and depth.
- Adds: per-bit write mask; configurable read latency; read-valid strobe; synchronous-reset-triggered memory init sweep with done flag.
- Sits under cache/TLB array wrappers; drop-in for vendor macros (active-low CEB/WEB/BWEB).

Parameters:
- Bits, 8, data width in bits (>=1)
- Word_Depth, 256, number of words (>=2, need not be power of two)
- Add_Width, 8, address width; must satisfy 2^Add_Width >= Word_Depth
- Read_Latency, 1, cycles from read request to Q valid; legal values 1 or 2
- Init_On_Reset, 1, 1 = reset starts an init sweep of every word; 0 = no sweep
- Init_Value, 0, Bits-wide value written to every word during the sweep

Ports:
- CLK  input  1  clock; all logic on posedge
- RST  input  1  synchronous reset, active-high
- CEB  input  1  chip enable, active-low
- WEB  input  1  write enable, active-low (0 = write, 1 = read)
- A  input  Add_Width  word address
- D  input  Bits  write data
- BWEB  input  Bits  bit-write enable, active-low; bit i written only when BWEB[i]=0
- Q  output  Bits  read data, registered
- QV  output  1  read-valid strobe, aligned with Q
- INIT_DONE  output  1  high when the array accepts requests

Behaviour:
- One clock (CLK); synchronous active-high reset (RST), sampled only on posedge CLK.
- FSM states: INIT, READY.
- RST=1 at an edge:
  - Next state is INIT if Init_On_Reset=1, else READY.
  - Sweep counter cleared to 0.
  - Q=0, QV=0, read pipeline flushed.
  - INIT_DONE=0 if Init_On_Reset=1, else 1.
  - Array contents are not otherwise touched by reset.
- INIT state:
  - Each cycle writes Init_Value to ram[cnt], then cnt increments.
  - After the write of word Word_Depth-1, next state is READY and INIT_DONE=1 on that same edge.
  - Sweep takes exactly Word_Depth cycles after RST deasserts.
  - All CEB/WEB requests are ignored: no write, no read, QV=0.
  - RST reasserted mid-sweep restarts the sweep at word 0.
- READY state:
  - Write (CEB=0, WEB=0): for every bit i with BWEB[i]=0, ram[A][i] <= D[i]. Bits with BWEB[i]=1 are unchanged. BWEB all-ones is a no-op write.
  - Read (CEB=0, WEB=1):
    - Data is ram[A] as it stood before this edge.
    - Read_Latency=1: Q and QV=1 update at the edge sampling the request.
    - Read_Latency=2: Q and QV=1 update one edge later. The pipeline accepts back-to-back reads every cycle.
  - Write cycle or CEB=1: that cycle's pipeline slot carries no read, so QV=0 at its output time. Q behaviour on such slots is set by the optional feature.
  - Out-of-range address (A >= Word_Depth): write is dropped; read returns 0 with QV=1.
- Read-after-write, same address: a read on the cycle after a write returns the written data.
- Single port: simultaneous read and write cannot occur.

Optional Feature:
- Macro: SRAM_RANDOM_OUT_EN.
- Defined: on any non-read slot, Q is loaded with $random truncated/replicated to Bits. This mimics macro output garbage and exposes consumers that sample Q without QV.
- Not defined: Q holds the last read data on non-read slots. Reset value stays 0 in both cases.
- QV behaviour is identical with or without the macro.

Test Plan:
- Init sweep (Word_Depth=16, Init_On_Reset=1, Init_Value=8'hA5): assert RST 2 cycles, then release.
  - INIT_DONE rises exactly 16 cycles later.
  - A read of each address 0..15 returns 8'hA5 with QV=1.
  - A request issued during the sweep is ignored: QV stays 0, memory unchanged.
- Bit mask: write D=8'hFF with BWEB=8'h00 to A=3, then D=8'h00 with BWEB=8'hF0 to A=3. Reading A=3 returns 8'hF0.
- Latency (Read_Latency=2): back-to-back reads of A=1,2,3 holding 8'h11,8'h22,8'h33.
  - Q/QV show 11,22,33 on the 2nd, 3rd and 4th edges after the first request.
  - QV=0 before and after.
- Reset mid-sweep: assert RST at sweep cycle 7. The sweep restarts at 0 and INIT_DONE rises 16 cycles after release.
- Out-of-range (Word_Depth=12, Add_Width=4): write 8'h5A to A=13, then read A=13. Returns 8'h00 with QV=1; ram[13 mod 16] is not created or altered.
- Non-read hold (macro undefined): read A=2 (=8'h22), then 3 idle cycles. Q stays 8'h22 and QV=0. With SRAM_RANDOM_OUT_EN defined, Q differs from 8'h22 on at least one idle cycle.
